// File: rtl/pixel_streamer.sv
// Raster-scan pixel source: walks the image BROM and feeds the masking core.
// Optional PIXEL_STREAMER_FRAME_LOOP_EN: stream frames back to back until reset.
module pixel_streamer #(
  parameter int IMG_ROWS = 320,
  parameter int IMG_COLS = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic [8:0]  mask_row_in,
  input  logic [7:0]  mask_col_in,
  output logic [16:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [11:0] mem_data,
  output logic [11:0] image_pixel,
  output logic [8:0]  pixel_row,
  output logic [7:0]  pixel_col,
  output logic [8:0]  mask_row_offset,
  output logic [7:0]  mask_col_offset,
  output logic        pixel_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

  localparam logic [8:0]  LAST_ROW = 9'(IMG_ROWS - 1);
  localparam logic [7:0]  LAST_COL = 8'(IMG_COLS - 1);
  localparam logic [16:0] COLS_W   = 17'(IMG_COLS);

  state_e      state_q, state_d;
  logic [8:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;
  logic [8:0]  mrow_q, mrow_d;
  logic [7:0]  mcol_q, mcol_d;
  logic        rd_en;
  logic        last_rd;

  logic        s1_vld_q;
  logic [8:0]  s1_row_q;
  logic [7:0]  s1_col_q;
  logic [8:0]  s1_mrow_q;
  logic [7:0]  s1_mcol_q;

  logic [11:0] pix_q;
  logic [8:0]  prow_q;
  logic [7:0]  pcol_q;
  logic [8:0]  orow_q;
  logic [7:0]  ocol_q;
  logic        vld_q;
  logic        done_q;

  assign last_rd = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mrow_d  = mrow_q;
    mcol_d  = mcol_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          row_d   = '0;
          col_d   = '0;
          mrow_d  = mask_row_in;
          mcol_d  = mask_col_in;
        end
      end
      READ: begin
        if (!pause) begin
          rd_en = 1'b1;
          if (last_rd) begin
            row_d = '0;
            col_d = '0;
`ifdef PIXEL_STREAMER_FRAME_LOOP_EN
            mrow_d = mask_row_in;
            mcol_d = mask_col_in;
`else
            state_d = DRAIN;
`endif
          end else if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 9'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        // Stage 1 empty means the final pixel is now in stage 2.
        if (!s1_vld_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      mrow_q    <= '0;
      mcol_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
      s1_mrow_q <= '0;
      s1_mcol_q <= '0;
      pix_q     <= '0;
      prow_q    <= '0;
      pcol_q    <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      mrow_q   <= mrow_d;
      mcol_q   <= mcol_d;
      s1_vld_q <= rd_en;
      if (rd_en) begin
        s1_row_q  <= row_q;
        s1_col_q  <= col_q;
        s1_mrow_q <= mrow_q;
        s1_mcol_q <= mcol_q;
      end
      vld_q  <= s1_vld_q;
      done_q <= s1_vld_q && (s1_row_q == LAST_ROW) &&
                (s1_col_q == LAST_COL);
      if (s1_vld_q) begin
        pix_q  <= mem_data;
        prow_q <= s1_row_q;
        pcol_q <= s1_col_q;
        orow_q <= s1_mrow_q;
        ocol_q <= s1_mcol_q;
      end
    end
  end

  assign mem_rd_en       = rd_en;
  assign mem_addr        = ({8'd0, row_q} * COLS_W) + {9'd0, col_q};
  assign image_pixel     = pix_q;
  assign pixel_row       = prow_q;
  assign pixel_col       = pcol_q;
  assign mask_row_offset = orow_q;
  assign mask_col_offset = ocol_q;
  assign pixel_valid     = vld_q;
  assign done            = done_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: 4x3 frame scenarios plus
// tall (512x2) and wide (2x256) instances for counter-width corners.
module tb_pixel_streamer;

  localparam int R = 4;
  localparam int C = 3;
  localparam int N = R * C;
  localparam int CMAX = 63;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst, start, pause;
  logic [8:0]  mrow_in;
  logic [7:0]  mcol_in;
  logic [16:0] addr;
  logic        rd;
  logic [11:0] mdata = '0;
  logic [11:0] pix;
  logic [8:0]  prow, mro;
  logic [7:0]  pcol, mco;
  logic        vld, busy, done;

  logic        start_b;
  logic [16:0] addr_b, addr_c;
  logic        rd_b, rd_c;
  logic [11:0] mdata_b = '0;
  logic [11:0] mdata_c = '0;
  logic [11:0] pix_b, pix_c;
  logic [8:0]  prow_b, prow_c, mro_b, mro_c;
  logic [7:0]  pcol_b, pcol_c, mco_b, mco_c;
  logic        vld_b, vld_c, busy_b, busy_c, done_b, done_c;

  logic        cap_rd[0:CMAX];
  logic [16:0] cap_addr[0:CMAX];
  logic        cap_vld[0:CMAX];
  logic [8:0]  cap_row[0:CMAX];
  logic [7:0]  cap_col[0:CMAX];
  logic [11:0] cap_pix[0:CMAX];
  logic [8:0]  cap_mro[0:CMAX];
  logic [7:0]  cap_mco[0:CMAX];
  logic        cap_done[0:CMAX];
  logic        cap_busy[0:CMAX];

  always #5 clk = ~clk;

  pixel_streamer #(.IMG_ROWS(R), .IMG_COLS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .mask_row_in(mrow_in), .mask_col_in(mcol_in),
    .mem_addr(addr), .mem_rd_en(rd), .mem_data(mdata),
    .image_pixel(pix), .pixel_row(prow), .pixel_col(pcol),
    .mask_row_offset(mro), .mask_col_offset(mco),
    .pixel_valid(vld), .busy(busy), .done(done)
  );

  pixel_streamer #(.IMG_ROWS(512), .IMG_COLS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(1'b0),
    .mask_row_in(9'd3), .mask_col_in(8'd4),
    .mem_addr(addr_b), .mem_rd_en(rd_b), .mem_data(mdata_b),
    .image_pixel(pix_b), .pixel_row(prow_b), .pixel_col(pcol_b),
    .mask_row_offset(mro_b), .mask_col_offset(mco_b),
    .pixel_valid(vld_b), .busy(busy_b), .done(done_b)
  );

  pixel_streamer #(.IMG_ROWS(2), .IMG_COLS(256)) dut_c (
    .clk(clk), .rst(rst), .start(start_b), .pause(1'b0),
    .mask_row_in(9'd3), .mask_col_in(8'd4),
    .mem_addr(addr_c), .mem_rd_en(rd_c), .mem_data(mdata_c),
    .image_pixel(pix_c), .pixel_row(prow_c), .pixel_col(pcol_c),
    .mask_row_offset(mro_c), .mask_col_offset(mco_c),
    .pixel_valid(vld_c), .busy(busy_c), .done(done_c)
  );

  // BROM models holding data = address
  always @(posedge clk) begin
    if (rd)   mdata   <= addr[11:0];
    if (rd_b) mdata_b <= addr_b[11:0];
    if (rd_c) mdata_c <= addr_c[11:0];
  end

  task automatic capture(input int ncyc, input int pf, input int pl,
                         input int rs);
    for (int c = 0; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c == rs);
      if (c == 0) begin
        mrow_in = 9'd1;
        mcol_in = 8'd2;
      end else begin
        mrow_in = 9'd7;
        mcol_in = 8'd7;
      end
      pause = (c >= pf) && (c < pf + pl);
      @(negedge clk);
      cap_rd[c]   = rd;
      cap_addr[c] = addr;
      cap_vld[c]  = vld;
      cap_row[c]  = prow;
      cap_col[c]  = pcol;
      cap_pix[c]  = pix;
      cap_mro[c]  = mro;
      cap_mco[c]  = mco;
      cap_done[c] = done;
      cap_busy[c] = busy;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    pause = 1'b0;
    mrow_in = 9'd5;
    mcol_in = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pix, prow, pcol, mro, mco, vld, busy, done, rd, addr} !== '0)
      $display("FAIL reset_state: got pix=%0d row=%0d col=%0d vld=%0b busy=%0b done=%0b rd=%0b addr=%0d, want all 0",
               pix, prow, pcol, vld, busy, done, rd, addr);
    if ({pix, prow, pcol, mro, mco, vld, busy, done, rd, addr} !== '0)
      errors++;
    rst = 1'b0;
    @(posedge clk);
  endtask

  // Vectors: plain frame, 2-cycle pause after read 5, ignored restart.
  task automatic test_frames();
    int pf_t[3];
    int pl_t[3];
    int rs_t[3];
    int dn_t[3];
    logic exp_rd[0:CMAX];
    int idx_rd[0:CMAX];
    pf_t = '{100, 6, 100};
    pl_t = '{0, 2, 0};
    rs_t = '{-1, -1, 5};
    dn_t = '{14, 16, 14};
    for (int v = 0; v < 3; v++) begin
      int issued, k, last_v, nv, nd;
      logic ev, ed, eb, ps;
      capture(22, pf_t[v], pl_t[v], rs_t[v]);
      issued = 0;
      last_v = 0;
      for (int c = 0; c <= 22; c++) begin
        ps = (c >= pf_t[v]) && (c < pf_t[v] + pl_t[v]);
        exp_rd[c] = (c >= 1) && (issued < N) && !ps;
        idx_rd[c] = issued;
        if (exp_rd[c]) issued++;
        if (c >= 2 && exp_rd[c-2]) last_v = c;
      end
      k = 0;
      nv = 0;
      nd = 0;
      for (int c = 0; c <= 22; c++) begin
        ev = (c >= 2) && exp_rd[c-2];
        ed = ev && (k == N - 1);
        eb = (c >= 1) && (c <= last_v);
        checks++;
        if (cap_rd[c] !== exp_rd[c] ||
            (exp_rd[c] && cap_addr[c] !== 17'(idx_rd[c]))) begin
          errors++;
          $display("FAIL v%0d rd c%0d: got rd=%0b addr=%0d, want rd=%0b addr=%0d",
                   v, c, cap_rd[c], cap_addr[c], exp_rd[c], idx_rd[c]);
        end
        checks++;
        if (cap_vld[c] !== ev) begin
          errors++;
          $display("FAIL v%0d valid c%0d: got %0b want %0b",
                   v, c, cap_vld[c], ev);
        end
        if (ev) begin
          checks++;
          if (cap_row[c] !== 9'(k / C) || cap_col[c] !== 8'(k % C) ||
              cap_pix[c] !== 12'(k) || cap_mro[c] !== 9'd1 ||
              cap_mco[c] !== 8'd2) begin
            errors++;
            $display("FAIL v%0d pixel c%0d: got (%0d,%0d) pix=%0d off=(%0d,%0d), want (%0d,%0d) pix=%0d off=(1,2)",
                     v, c, cap_row[c], cap_col[c], cap_pix[c], cap_mro[c],
                     cap_mco[c], k / C, k % C, k);
          end
          k++;
        end
        checks++;
        if (cap_done[c] !== ed || cap_busy[c] !== eb) begin
          errors++;
          $display("FAIL v%0d done/busy c%0d: got %0b/%0b want %0b/%0b",
                   v, c, cap_done[c], cap_busy[c], ed, eb);
        end
        if (cap_vld[c] === 1'b1) nv++;
        if (cap_done[c] === 1'b1) nd++;
      end
      checks++;
      if (cap_done[dn_t[v]] !== 1'b1 || cap_busy[dn_t[v] + 1] !== 1'b0 ||
          nv != N || nd != 1) begin
        errors++;
        $display("FAIL v%0d frame_end: done@%0d=%0b busy@next=%0b pixels=%0d dones=%0d, want 1/0/%0d/1",
                 v, dn_t[v], cap_done[dn_t[v]], cap_busy[dn_t[v] + 1],
                 nv, nd, N);
      end
    end
  endtask

  task automatic test_mid_reset();
    int nv;
    int first;
    capture(8, 100, 0, -1);
    checks++;
    if (vld !== 1'b1 || pix !== 12'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got vld=%0b pix=%0d busy=%0b, want 1/6/1",
               vld, pix, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pix, prow, pcol, mro, mco, vld, busy, done, rd, addr} !== '0) begin
      errors++;
      $display("FAIL async_reset: got pix=%0d row=%0d col=%0d vld=%0b busy=%0b rd=%0b addr=%0d, want all 0",
               pix, prow, pcol, vld, busy, rd, addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    capture(20, 100, 0, -1);
    nv = 0;
    first = -1;
    for (int c = 0; c <= 20; c++) begin
      if (cap_vld[c] === 1'b1) begin
        if (first < 0) first = c;
        nv++;
      end
    end
    checks++;
    if (first != 3 || cap_row[3] !== 9'd0 || cap_col[3] !== 8'd0 ||
        cap_pix[3] !== 12'd0 || nv != N || cap_done[14] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_frame: first=%0d (%0d,%0d) pix=%0d pixels=%0d done14=%0b, want 3 (0,0) 0 %0d 1",
               first, cap_row[3], cap_col[3], cap_pix[3], nv, cap_done[14], N);
    end
  endtask

  task automatic test_boundary();
    int cnt_b, cnt_c, bad_b, bad_c, dn_b, dn_c;
    logic [16:0] la_b, la_c;
    logic [8:0]  dr_b, dr_c;
    logic [7:0]  dc_b, dc_c;
    cnt_b = 0; cnt_c = 0; bad_b = 0; bad_c = 0; dn_b = 0; dn_c = 0;
    la_b = '0; la_c = '0; dr_b = '0; dr_c = '0; dc_b = '0; dc_c = '0;
    @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (rd_b) la_b = addr_b;
      if (rd_c) la_c = addr_c;
      if (vld_b) begin
        cnt_b++;
        if (int'(pix_b) != (int'(prow_b) * 2 + int'(pcol_b)) % 4096) bad_b++;
      end
      if (vld_c) begin
        cnt_c++;
        if (int'(pix_c) != int'(prow_c) * 256 + int'(pcol_c)) bad_c++;
      end
      if (done_b) begin
        dn_b++;
        dr_b = prow_b;
        dc_b = pcol_b;
      end
      if (done_c) begin
        dn_c++;
        dr_c = prow_c;
        dc_c = pcol_c;
      end
    end
    checks++;
    if (la_b !== 17'd1023 || dr_b !== 9'd511 || dc_b !== 8'd1) begin
      errors++;
      $display("FAIL tall_last: got addr=%0d (%0d,%0d), want 1023 (511,1)",
               la_b, dr_b, dc_b);
    end
    checks++;
    if (cnt_b != 1024 || bad_b != 0 || dn_b != 1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL tall_frame: got pixels=%0d bad=%0d dones=%0d busy=%0b, want 1024/0/1/0",
               cnt_b, bad_b, dn_b, busy_b);
    end
    checks++;
    if (la_c !== 17'd511 || dr_c !== 9'd1 || dc_c !== 8'd255) begin
      errors++;
      $display("FAIL wide_last: got addr=%0d (%0d,%0d), want 511 (1,255)",
               la_c, dr_c, dc_c);
    end
    checks++;
    if (cnt_c != 512 || bad_c != 0 || dn_c != 1 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL wide_frame: got pixels=%0d bad=%0d dones=%0d busy=%0b, want 512/0/1/0",
               cnt_c, bad_c, dn_c, busy_c);
    end
  endtask

  task automatic test_frame_loop();
    int k;
    logic [8:0] er;
    logic [7:0] ec;
    capture(40, 100, 0, -1);
    for (int c = 3; c <= 40; c++) begin
      k = (c - 3) % N;
      er = (c - 3 < N) ? 9'd1 : 9'd7;
      ec = (c - 3 < N) ? 8'd2 : 8'd7;
      checks++;
      if (cap_vld[c] !== 1'b1 || cap_row[c] !== 9'(k / C) ||
          cap_col[c] !== 8'(k % C) || cap_pix[c] !== 12'(k) ||
          cap_mro[c] !== er || cap_mco[c] !== ec ||
          cap_done[c] !== (k == N - 1) || cap_busy[c] !== 1'b1) begin
        errors++;
        $display("FAIL loop c%0d: got vld=%0b (%0d,%0d) pix=%0d off=(%0d,%0d) done=%0b busy=%0b, want 1 (%0d,%0d) %0d (%0d,%0d) %0b 1",
                 c, cap_vld[c], cap_row[c], cap_col[c], cap_pix[c],
                 cap_mro[c], cap_mco[c], cap_done[c], cap_busy[c],
                 k / C, k % C, k, er, ec, k == N - 1);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || vld !== 1'b0) begin
      errors++;
      $display("FAIL loop_reset: got busy=%0b vld=%0b, want 0/0", busy, vld);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef PIXEL_STREAMER_FRAME_LOOP_EN
    test_frame_loop();
`else
    test_frames();
    test_mid_reset();
    test_boundary();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
